symbol_seq_detector: RTL
========================

SYMBOL_SEQ_DETECTOR -- requirements
Module: symbol_seq_detector

Interface
REQ-001 SHALL have parameter SYM_W, default 2, width in bits of one input symbol (SYM_W=2 is the {x,y} pair).
REQ-002 SHALL have parameter DEPTH, default 4, number of symbols in the detected pattern.
REQ-003 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-004 SHALL have parameter OVERLAP, default 1; 1 means overlapping matches are counted, 0 means matches never share symbols.
REQ-005 SHALL restrict parameters to SYM_W>=1, DEPTH>=2, CNT_W>=1, OVERLAP in {0,1}.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_sym, input, SYM_W, the input symbol.
REQ-009 SHALL have port in_valid, input, 1, qualifies in_sym for the current cycle.
REQ-010 SHALL have port load, input, 1, pattern-load strobe.
REQ-011 SHALL have port load_pattern, input, SYM_W*DEPTH, the pattern; first expected symbol in the MSBs, last in the LSBs.
REQ-012 SHALL have port out_z, output, 1, registered Moore match flag.
REQ-013 SHALL have port match_count, output, CNT_W, number of matches since the last reset or load.
REQ-014 SHALL have port armed, output, 1, high once a pattern has been loaded.

Function
REQ-015 SHALL hold the internal state pattern register, symbol history (DEPTH symbols, newest in LSBs), fill counter 0..DEPTH, armed, out_z and match_count.
REQ-016 SHALL, when load=1 (and reset=0), capture load_pattern, clear history, fill and match_count, set armed=1 and drive out_z=0 next cycle.
REQ-017 SHALL give load priority over in_valid; a symbol presented in the load cycle is dropped.
REQ-018 SHALL ignore in_valid and keep out_z=0 while armed=0.
REQ-019 SHALL, when armed=1, load=0 and in_valid=1, shift in_sym into the history and set fill to min(fill+1, DEPTH).
REQ-020 SHALL declare a match when the updated fill equals DEPTH and the updated history equals the pattern.
REQ-021 SHALL set out_z=1 for exactly the cycle following the edge that accepted the completing symbol; otherwise out_z=0, including all cycles with in_valid=0.
REQ-022 SHALL increment match_count on the same edge out_z is set, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL, with OVERLAP=1, leave fill at DEPTH after a match, so each further matching symbol can complete another match.
REQ-024 SHALL, with OVERLAP=0, clear fill to 0 on a match, so the next match needs DEPTH new symbols.
REQ-025 SHALL hold history, fill and match_count unchanged on cycles with in_valid=0; gaps do not break a partial sequence.
REQ-026 SHALL have a latency of one cycle from accepting the completing symbol to out_z and match_count being visible.

Reset
REQ-027 SHALL, on reset=1 at a rising clk edge, clear pattern, history, fill, armed, out_z and match_count to 0, with priority over load and in_valid.
REQ-028 SHALL, after reset mid-sequence, discard all partial progress and require a new load before any detection.

Verification
REQ-029 SHALL cover: reset, then in_valid=1 with symbols 0,1,2,3 and no load -> armed=0, out_z=0, match_count=0 throughout.
REQ-030 SHALL cover: load 8'b00_01_10_11, then feed 0,1,2,3 on consecutive cycles -> out_z high for exactly one cycle after the 4th symbol, match_count=1.
REQ-031 SHALL cover: load 8'b01_01_01_01, feed seven symbols of 1 -> OVERLAP=1 gives match_count=4 (out_z high 4 consecutive cycles); OVERLAP=0 gives match_count=1.
REQ-032 SHALL cover: pattern 0,1,2,3 fed with in_valid low for 2 cycles between each symbol -> one match, out_z low during the gaps.
REQ-033 SHALL cover: CNT_W=2, OVERLAP=1, pattern all-1, feed eight 1 symbols -> 5 matches, match_count saturates at 3.
REQ-034 SHALL cover: pattern 0,1,2,3, feed 0,1,2, assert reset, reload the same pattern, feed 3 -> no match, match_count=0; load together with in_valid in one cycle -> that symbol is dropped.

Source files
------------

// File: rtl/symbol_seq_detector.sv
// Programmable symbol-sequence detector. Counts occurrences of a loaded
// DEPTH-symbol pattern in a qualified input stream, with optional overlap.
module symbol_seq_detector #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   in_valid,
  input  logic                   load,
  input  logic [SYM_W*DEPTH-1:0] load_pattern,
  output logic                   out_z,
  output logic [CNT_W-1:0]       match_count,
  output logic                   armed
);

  localparam int unsigned PatW  = SYM_W * DEPTH;
  localparam int unsigned FillW = $clog2(DEPTH + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(DEPTH);

  if (SYM_W < 1 || DEPTH < 2 || CNT_W < 1 || OVERLAP > 1) begin : gen_param_check
    $error("symbol_seq_detector: illegal parameter combination");
  end

  logic [PatW-1:0]  pattern_q, pattern_d;
  logic [PatW-1:0]  hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             out_z_q, out_z_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: load beats symbol acceptance; nothing is accepted until armed.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    armed_d   = armed_q;
    count_d   = count_q;
    out_z_d   = 1'b0;

    if (load) begin
      pattern_d = load_pattern;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      armed_d   = 1'b1;
    end else if (armed_q && in_valid) begin
      // Newest symbol enters the LSBs, so a full history reads oldest-first
      // from the MSBs, matching the pattern layout.
      hist_d = {hist_q[PatW-SYM_W-1:0], in_sym};
      fill_d = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
      if (fill_d == FillFull && hist_d == pattern_q) begin
        out_z_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + 1'b1;
        end
        if (OVERLAP == 0) begin
          fill_d = '0;
        end
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      out_z_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      out_z_q   <= out_z_d;
      count_q   <= count_d;
    end
  end

  assign out_z       = out_z_q;
  assign match_count = count_q;
  assign armed       = armed_q;

endmodule
